// File: rtl/board_io_pkg.sv
// Shared definitions for board-input blocks.
//   MODE_FOLLOW / MODE_TOGGLE : LED drive mode encodings
//   cnt_width()               : width of a counter that must hold values 0..max_count
package board_io_pkg;

  localparam logic MODE_FOLLOW = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

  // Width of a counter that can represent max_count, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    int unsigned w;
    w = $clog2(max_count + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debouncer_bank_if.sv
// Switch-bank signal bundle.
//   SW, MODE, CLR                         : driven by the board side (master)
//   SW_DB, RISE, FALL, ANY_CHANGE, LEDR   : driven by the debouncer bank (slave)
interface switch_debouncer_bank_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] SW;
  logic             MODE;
  logic             CLR;
  logic [WIDTH-1:0] SW_DB;
  logic [WIDTH-1:0] RISE;
  logic [WIDTH-1:0] FALL;
  logic             ANY_CHANGE;
  logic [WIDTH-1:0] LEDR;

  modport master (
    output SW, MODE, CLR,
    input  SW_DB, RISE, FALL, ANY_CHANGE, LEDR
  );

  modport slave (
    input  SW, MODE, CLR,
    output SW_DB, RISE, FALL, ANY_CHANGE, LEDR
  );
endinterface

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchroniser, stability counter, debounced level
// and registered one-cycle rise/fall strobes.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   sw_i    : raw asynchronous switch input
//   sw_db_o : debounced level
//   rise_o  : high for the cycle sw_db_o first shows 1
//   fall_o  : high for the cycle sw_db_o first shows 0
module debounce_channel
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_i,
  output logic sw_db_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned   CntW   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            db_q, db_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the accepted level; any agreeing
  // sample restarts the count, so a bounce never reaches CntMax.
  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q != db_q) begin
      if (cnt_q == CntMax) begin
        db_d   = s2_q;
        rise_d = s2_q;
        fall_d = ~s2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= sw_i;
      s2_q   <= s1_q;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sw_db_o = db_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debouncer_bank.sv
// Bank of debounced board switches driving LEDs.
//   CLOCK_50 : system clock, rising edge
//   RST      : asynchronous active-high reset
//   bus      : slave side of the switch bundle
//              SW (raw), MODE (0 follow / 1 toggle), CLR (clear toggle latches)
//              SW_DB, RISE, FALL, ANY_CHANGE, LEDR
// Each channel is debounced independently; the top keeps the per-channel toggle
// latches, the LED mode mux and the any-change reduction.
module switch_debouncer_bank
  import board_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic                    CLOCK_50,
  input logic                    RST,
  switch_debouncer_bank_if.slave bus
);

  logic [WIDTH-1:0] sw_db;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] t_q, t_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i  (CLOCK_50),
      .rst_i  (RST),
      .sw_i   (bus.SW[i]),
      .sw_db_o(sw_db[i]),
      .rise_o (rise[i]),
      .fall_o (fall[i])
    );
  end

  // Clear wins over a coincident rise; latches keep updating in follow mode.
  always_comb begin
    t_d = t_q ^ rise;
    if (bus.CLR) begin
      t_d = '0;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      t_q <= '0;
    end else begin
      t_q <= t_d;
    end
  end

  assign bus.SW_DB      = sw_db;
  assign bus.RISE       = rise;
  assign bus.FALL       = fall;
  assign bus.ANY_CHANGE = |(rise | fall);
  assign bus.LEDR       = (bus.MODE == MODE_TOGGLE) ? t_q : sw_db;

endmodule

// File: tb/tb_switch_debouncer_bank.sv
module tb_switch_debouncer_bank;

  logic CLOCK_50 = 1'b0;
  logic RST      = 1'b0;

  switch_debouncer_bank_if #(.WIDTH(4)) bus ();

  switch_debouncer_bank #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RST     (RST),
    .bus     (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int unsigned due;
    string       tag;
    logic [3:0]  db;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  ledr;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned edge_no = 0;
  int unsigned checks  = 0;
  int unsigned errors  = 0;
  logic [3:0]  db_exp  = 4'h0;
  logic [3:0]  t_exp   = 4'h0;
  logic        mode_exp = 1'b0;

  function automatic logic [3:0] ledr_of(input logic [3:0] db, input logic [3:0] t);
    return mode_exp ? t : db;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] db, input logic [3:0] rise,
                            input logic [3:0] fall, input logic [3:0] ledr);
    chk({tag, ".sw_db"}, 32'(bus.SW_DB), 32'(db));
    chk({tag, ".rise"},  32'(bus.RISE),  32'(rise));
    chk({tag, ".fall"},  32'(bus.FALL),  32'(fall));
    chk({tag, ".any"},   32'(bus.ANY_CHANGE), 32'(|(rise | fall)));
    chk({tag, ".ledr"},  32'(bus.LEDR),  32'(ledr));
  endtask

  task automatic push(input int unsigned due, input string tag, input logic [3:0] db,
                      input logic [3:0] rise, input logic [3:0] fall, input logic [3:0] ledr);
    exp_t x;
    x.due  = due;
    x.tag  = tag;
    x.db   = db;
    x.rise = rise;
    x.fall = fall;
    x.ledr = ledr;
    sb_q.push_back(x);
  endtask

  // Advance one clock; compare every expectation due after this edge on the falling edge.
  task automatic tick();
    @(posedge CLOCK_50);
    edge_no++;
    @(negedge CLOCK_50);
    while (sb_q.size() > 0 && sb_q[0].due <= edge_no) begin
      exp_t x;
      x = sb_q.pop_front();
      chk({x.tag, ".due"}, edge_no, x.due);
      check_outs(x.tag, x.db, x.rise, x.fall, x.ledr);
    end
  endtask

  // Drive a new switch value, hold it, and expect the debounced update D+2 edges after
  // the drive (first sample at the next edge, update D+1 edges after that).
  task automatic change_sw(input string tag, input logic [3:0] new_sw, input bit clr_on_rise);
    int unsigned e;
    logic [3:0]  rise;
    logic [3:0]  fall;
    logic [3:0]  t_new;
    e     = edge_no;
    rise  = new_sw & ~db_exp;
    fall  = ~new_sw & db_exp;
    t_new = clr_on_rise ? 4'h0 : (t_exp ^ rise);
    bus.SW = new_sw;
    push(e + 1, {tag, "_first"}, db_exp, 4'h0, 4'h0, ledr_of(db_exp, t_exp));
    push(e + 5, {tag, "_pre"},   db_exp, 4'h0, 4'h0, ledr_of(db_exp, t_exp));
    push(e + 6, {tag, "_edge"},  new_sw, rise, fall, ledr_of(new_sw, t_exp));
    push(e + 7, {tag, "_post"},  new_sw, 4'h0, 4'h0, ledr_of(new_sw, t_new));
    repeat (6) tick();
    bus.CLR = clr_on_rise;
    tick();
    bus.CLR = 1'b0;
    db_exp  = new_sw;
    t_exp   = t_new;
  endtask

  task automatic clr_pulse(input string tag);
    bus.CLR = 1'b1;
    push(edge_no + 1, tag, db_exp, 4'h0, 4'h0, ledr_of(db_exp, 4'h0));
    tick();
    bus.CLR = 1'b0;
    t_exp   = 4'h0;
  endtask

  initial begin
    int unsigned e;
    logic [7:0]  pat;
    logic [3:0]  tog_tbl [3];

    bus.SW   = 4'hF;
    bus.MODE = 1'b0;
    bus.CLR  = 1'b0;
    #1 RST = 1'b1;
    #1 check_outs("rst_async", 4'h0, 4'h0, 4'h0, 4'h0);

    // 1: held in reset with switches high, then release.
    for (int i = 0; i < 3; i++) begin
      push(edge_no + 1, "rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
      tick();
    end
    RST = 1'b0;
    change_sw("rst_release", 4'hF, 1'b0);
    change_sw("all_fall", 4'h0, 1'b0);

    // Toggle latches picked up the release rise; show them, then clear.
    bus.MODE = 1'b1;
    mode_exp = 1'b1;
    #1 chk("mode_to_toggle.ledr", 32'(bus.LEDR), 32'h0000_000F);
    clr_pulse("clr_only");
    bus.MODE = 1'b0;
    mode_exp = 1'b0;

    // 2: single-channel latency.
    change_sw("latency", 4'b0001, 1'b0);

    // 3: bounce on channel 1 never reaches the threshold.
    pat = 8'b0111_0101;
    e   = edge_no;
    for (int i = 1; i <= 14; i++) begin
      push(e + i, "bounce", 4'b0001, 4'h0, 4'h0, 4'b0001);
    end
    for (int i = 0; i < 8; i++) begin
      bus.SW[1] = pat[i];
      tick();
    end
    repeat (6) tick();

    // 4: toggle mode on channel 2.
    bus.MODE = 1'b1;
    mode_exp = 1'b1;
    #1 chk("mode_toggle.ledr", 32'(bus.LEDR), 32'(t_exp));
    clr_pulse("toggle_clr");
    tog_tbl[0] = 4'b0100;
    tog_tbl[1] = 4'b0000;
    tog_tbl[2] = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      change_sw("press", 4'b0101, 1'b0);
      chk($sformatf("toggle_%0d.ledr", k), 32'(bus.LEDR), 32'(tog_tbl[k]));
      change_sw("release", 4'b0001, 1'b0);
    end
    bus.MODE = 1'b0;
    mode_exp = 1'b0;
    #1 chk("mode_follow.ledr", 32'(bus.LEDR), 32'h0000_0001);
    bus.MODE = 1'b1;
    mode_exp = 1'b1;
    #1 chk("mode_back.ledr", 32'(bus.LEDR), 32'h0000_0004);

    // 5: clear coincident with a rise on channel 0.
    clr_pulse("prio_clr");
    change_sw("prio_fall_a", 4'b0000, 1'b0);
    change_sw("prio_rise_a", 4'b0001, 1'b0);
    chk("prio_t1.ledr", 32'(bus.LEDR), 32'h0000_0001);
    change_sw("prio_fall_b", 4'b0000, 1'b0);
    change_sw("prio_clr_t1", 4'b0001, 1'b1);
    change_sw("prio_fall_c", 4'b0000, 1'b0);
    change_sw("prio_clr_t0", 4'b0001, 1'b1);
    chk("prio_t0.ledr", 32'(bus.LEDR), 32'h0000_0000);
    bus.MODE = 1'b0;
    mode_exp = 1'b0;

    // 6: reset in the middle of a count on channel 3.
    bus.SW = 4'b1001;
    e      = edge_no;
    for (int i = 1; i <= 4; i++) begin
      push(e + i, "midcnt", 4'b0001, 4'h0, 4'h0, 4'b0001);
    end
    repeat (4) tick();
    RST = 1'b1;
    #1 check_outs("mid_rst_async", 4'h0, 4'h0, 4'h0, 4'h0);
    push(edge_no + 1, "mid_rst_hold", 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    RST    = 1'b0;
    db_exp = 4'h0;
    t_exp  = 4'h0;
    change_sw("mid_rst_release", 4'b1001, 1'b0);

    repeat (2) tick();
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
